// File: rtl/div_arb_pkg.sv
// div_arb_pkg: FSM encoding, divider sizing, divide-by-zero saturation and round-robin helpers
package div_arb_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] BUSY = 2'd2;
  localparam logic [1:0] RESP = 2'd3;
  function automatic int ED_WIDTH(input int d);
    return 2 * d;
  endfunction
  // +/-(2^(w-1)-1) in 64 bits; callers keep the low w bits
  function automatic logic [63:0] dbz_sat(input int w, input logic neg);
    logic [63:0] m;
    m = (64'd1 << (w - 1)) - 64'd1;
    return neg ? -m : m;
  endfunction
  // first set bit of v scanning from last+1, wrapping modulo n; -1 when none
  function automatic int rr_next(input logic [31:0] v, input int last, input int n);
    int g;
    g = -1;
    for (int k = n; k >= 1; k--) if (v[5'((last + k) % n)]) g = (last + k) % n;
    return g;
  endfunction
endpackage

// File: rtl/div_arbiter_if.sv
// div_arbiter_if: requester-side request/response bundle of the shared divider
interface div_arbiter_if #(parameter int N_REQ = 4, parameter int D_WIDTH = 32, parameter int TAG_W = 4);
  logic [N_REQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N_REQ-1:0][D_WIDTH-1:0] req_dividend, req_divisor;
  logic [N_REQ-1:0][TAG_W-1:0] req_tag;
  logic [D_WIDTH-1:0] rsp_quotient;
  logic [TAG_W-1:0] rsp_tag;
  logic rsp_dbz;
  modport master(output req_valid, req_dividend, req_divisor, req_tag, rsp_ready,
                 input req_ready, rsp_valid, rsp_quotient, rsp_tag, rsp_dbz);
  modport slave(input req_valid, req_dividend, req_divisor, req_tag, rsp_ready,
                output req_ready, rsp_valid, rsp_quotient, rsp_tag, rsp_dbz);
endinterface

// File: rtl/div_core.sv
// div_core: signed fixed-point non-restoring divider, round half up, one quotient bit per cycle
module div_core import div_arb_pkg::*; #(
  parameter int D_WIDTH = 32,
  parameter int Q_BITS = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [D_WIDTH-1:0] dividend,
  input  logic [D_WIDTH-1:0] divisor,
  output logic [D_WIDTH-1:0] quotient,
  output logic               done
);
  localparam int EW = ED_WIDTH(D_WIDTH);
  localparam int AW = D_WIDTH + 2;
  localparam int CW = $clog2(EW);
  logic [AW-1:0] acc, acc_sh, acc_dif, acc_nx;
  logic [EW-1:0] qr, q_nx, num;
  logic [D_WIDTH:0] am_s, bm_s, bm;
  logic [CW-1:0] cnt;
  logic neg, busy;
  // one extra bit so the most negative operand has a representable magnitude
  assign am_s = dividend[D_WIDTH-1] ? -{dividend[D_WIDTH-1], dividend} : {1'b0, dividend};
  assign bm_s = divisor[D_WIDTH-1] ? -{divisor[D_WIDTH-1], divisor} : {1'b0, divisor};
  assign num = (EW'(am_s) << Q_BITS) + EW'(bm_s >> 1);
  assign acc_sh = {acc[AW-2:0], qr[EW-1]};
  assign acc_dif = acc[AW-1] ? acc_sh + {1'b0, bm} : acc_sh - {1'b0, bm};
  assign q_nx = {qr[EW-2:0], ~acc_dif[AW-1]};
  assign acc_nx = (cnt == '0 && acc_dif[AW-1]) ? acc_dif + {1'b0, bm} : acc_dif;
  // done and quotient come straight from the last iteration so the caller sees them that cycle
  assign done = busy && cnt == '0;
  assign quotient = neg ? -q_nx[D_WIDTH-1:0] : q_nx[D_WIDTH-1:0];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      busy <= 1'b0;
      cnt <= '0;
      acc <= '0;
      qr <= '0;
      bm <= '0;
      neg <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= CW'(EW - 1);
      acc <= '0;
      qr <= num;
      bm <= bm_s;
      neg <= dividend[D_WIDTH-1] ^ divisor[D_WIDTH-1];
    end else if (busy) begin
      acc <= acc_nx;
      qr <= q_nx;
      cnt <= cnt - 1'b1;
      busy <= cnt != '0;
    end
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one iterative fixed-point divider among N_REQ requesters
module div_arbiter import div_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int D_WIDTH = 32,
  parameter int Q_BITS = 10,
  parameter int TAG_W = 4
) (
  input logic clock,
  input logic reset,
  div_arbiter_if.slave bus
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  logic [1:0] state;
  logic [IW-1:0] last, win, gi;
  logic [D_WIDTH-1:0] a_r, b_r, q_r, core_q;
  logic [TAG_W-1:0] tag_r;
  logic dbz_r, start, done;
  int g;
  always_comb g = rr_next(32'(bus.req_valid), int'(last), N_REQ);
  assign gi = IW'(g);
  assign start = state == LOAD;
  // grant is withheld during reset so nothing is accepted while the FSM is being cleared
  assign bus.req_ready = (state == IDLE && !reset && g >= 0) ? N_REQ'(1) << gi : '0;
  assign bus.rsp_valid = state == RESP ? N_REQ'(1) << win : '0;
  assign bus.rsp_quotient = q_r;
  assign bus.rsp_tag = tag_r;
  assign bus.rsp_dbz = dbz_r;
  div_core #(.D_WIDTH(D_WIDTH), .Q_BITS(Q_BITS)) u_core (
    .clock(clock), .reset(reset), .start(start), .dividend(a_r), .divisor(b_r),
    .quotient(core_q), .done(done)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      last <= IW'(N_REQ - 1);
      win <= '0;
      a_r <= '0;
      b_r <= '0;
      q_r <= '0;
      tag_r <= '0;
      dbz_r <= 1'b0;
    end else begin
      if (state == IDLE && g >= 0) begin
        a_r <= bus.req_dividend[gi];
        b_r <= bus.req_divisor[gi];
        tag_r <= bus.req_tag[gi];
        win <= gi;
        last <= gi;
        state <= LOAD;
      end
      if (state == LOAD) begin
        dbz_r <= b_r == '0;
        if (b_r == '0) q_r <= D_WIDTH'(dbz_sat(D_WIDTH, a_r[D_WIDTH-1]));
        state <= b_r == '0 ? RESP : BUSY;
      end
      if (state == BUSY && done) begin
        q_r <= core_q;
        state <= RESP;
      end
      if (state == RESP && bus.rsp_ready[win]) state <= IDLE;
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed self-checking bench for the shared divider arbiter
module tb_div_arbiter;
  logic clock = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  div_arbiter_if bus();
  div_arbiter dut(.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                       output int lat, output logic [3:0] rv, output logic [31:0] q,
                       output logic [3:0] t, output logic d);
    lat = -1; rv = '0; q = '0; t = '0; d = 1'b0;
    @(posedge clock); #1;
    bus.req_dividend[2'(idx)] = a;
    bus.req_divisor[2'(idx)] = b;
    bus.req_tag[2'(idx)] = tag;
    bus.req_valid = 4'(1) << idx;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      @(negedge clock);
      if (bus.req_ready[2'(idx)]) lat = 0;
    end
    @(posedge clock); #1;
    bus.req_valid = '0;
    if (lat < 0) return;
    lat = -1;
    for (int c = 1; c <= 200 && rv == '0; c++) begin
      @(negedge clock);
      if (bus.rsp_valid != '0) begin
        lat = c; rv = bus.rsp_valid; q = bus.rsp_quotient; t = bus.rsp_tag; d = bus.rsp_dbz;
      end
    end
    bus.rsp_ready = rv;
    @(posedge clock); #1;
    bus.rsp_ready = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.req_valid = 4'b0001;
    bus.rsp_ready = '0;
    bus.req_dividend = '0;
    bus.req_divisor = '0;
    bus.req_tag = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (bus.req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 4'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid); end
    checks++; if (bus.rsp_quotient !== 32'd0) begin failures++; $display("FAIL reset_quotient: got %h expected 0", bus.rsp_quotient); end
    checks++; if (bus.rsp_tag !== 4'd0) begin failures++; $display("FAIL reset_tag: got %h expected 0", bus.rsp_tag); end
    checks++; if (bus.rsp_dbz !== 1'b0) begin failures++; $display("FAIL reset_dbz: got %b expected 0", bus.rsp_dbz); end
    bus.req_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single;
    int lat; logic [3:0] rv, t; logic [31:0] q; logic d;
    do_op(2, 32'd3072, 32'd2048, 4'd5, lat, rv, q, t, d);
    checks++; if (lat !== 66) begin failures++; $display("FAIL single_latency: got %0d expected 66", lat); end
    checks++; if (rv !== 4'b0100) begin failures++; $display("FAIL single_rsp_valid: got %b expected 0100", rv); end
    checks++; if (q !== 32'd1536) begin failures++; $display("FAIL single_quotient: got %0d expected 1536", q); end
    checks++; if (t !== 4'd5) begin failures++; $display("FAIL single_tag: got %0d expected 5", t); end
    checks++; if (d !== 1'b0) begin failures++; $display("FAIL single_dbz: got %b expected 0", d); end
  endtask

  task automatic test_signs;
    int lat; logic [3:0] rv, t; logic [31:0] q; logic d;
    logic [31:0] sa [4];
    logic [31:0] sb [4];
    logic [31:0] sq [4];
    sa = '{32'hFFFFFC00, 32'h00000400, 32'hFFFFFC00, 32'h00000001};
    sb = '{32'h00000C00, 32'hFFFFF400, 32'hFFFFF400, 32'h00000C00};
    sq = '{32'hFFFFFEAB, 32'hFFFFFEAB, 32'h00000155, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      do_op(1, sa[i], sb[i], 4'(i), lat, rv, q, t, d);
      checks++; if (q !== sq[i]) begin failures++; $display("FAIL signs_quotient[%0d]: got %h expected %h", i, q, sq[i]); end
      checks++; if (rv !== 4'b0010 || d !== 1'b0 || lat !== 66) begin failures++; $display("FAIL signs_rsp[%0d]: got valid=%b dbz=%b lat=%0d expected 0010/0/66", i, rv, d, lat); end
    end
  endtask

  task automatic test_dbz;
    int lat; logic [3:0] rv, t; logic [31:0] q; logic d;
    do_op(0, 32'd5120, 32'd0, 4'd7, lat, rv, q, t, d);
    checks++; if (q !== 32'h7FFFFFFF) begin failures++; $display("FAIL dbz_pos_quotient: got %h expected 7fffffff", q); end
    checks++; if (d !== 1'b1 || t !== 4'd7) begin failures++; $display("FAIL dbz_pos_flag: got dbz=%b tag=%0d expected 1/7", d, t); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL dbz_pos_latency: got %0d expected 2", lat); end
    do_op(3, 32'hFFFFEC00, 32'd0, 4'd8, lat, rv, q, t, d);
    checks++; if (q !== 32'h80000001) begin failures++; $display("FAIL dbz_neg_quotient: got %h expected 80000001", q); end
    checks++; if (d !== 1'b1 || rv !== 4'b1000) begin failures++; $display("FAIL dbz_neg_flag: got dbz=%b valid=%b expected 1/1000", d, rv); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL dbz_neg_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_round_robin;
    int c, ex, bad;
    logic [3:0] gr, rv;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      bus.req_dividend[2'(i)] = 32'((i + 1) * 1024);
      bus.req_divisor[2'(i)] = 32'd1024;
      bus.req_tag[2'(i)] = 4'(i);
    end
    bus.req_valid = 4'hF;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      ex = k % 4;
      gr = '0;
      for (c = 0; c < 100; c++) begin
        gr = bus.req_ready;
        if (gr != '0) break;
        @(negedge clock);
      end
      checks++; if (gr !== 4'(1) << ex) begin failures++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, gr, 4'(1) << ex); end
      if (k > 0) begin
        checks++; if (c !== 0) begin failures++; $display("FAIL rr_gap[%0d]: got %0d idle cycles expected 0", k, c); end
      end
      @(posedge clock); #1;
      if (k == 4) bus.req_valid = '0;
      bad = 0; rv = '0;
      for (c = 0; c < 100 && rv == '0; c++) begin
        @(negedge clock);
        if (bus.req_ready != '0) bad++;
        rv = bus.rsp_valid;
      end
      checks++; if (rv !== 4'(1) << ex || bus.rsp_quotient !== 32'((ex + 1) * 1024)) begin failures++; $display("FAIL rr_resp[%0d]: got valid=%b q=%0d expected %b/%0d", k, rv, bus.rsp_quotient, 4'(1) << ex, (ex + 1) * 1024); end
      checks++; if (bad !== 0) begin failures++; $display("FAIL rr_ready_while_busy[%0d]: got %0d cycles expected 0", k, bad); end
      bus.rsp_ready = rv;
      #1;
      checks++; if (bus.req_ready !== 4'b0) begin failures++; $display("FAIL rr_accept_with_rsp_ready[%0d]: got %b expected 0000", k, bus.req_ready); end
      @(posedge clock); #1;
      bus.rsp_ready = '0;
    end
  endtask

  task automatic test_back_pressure;
    int bad;
    logic [3:0] rv;
    @(posedge clock); #1;
    bus.req_dividend[3] = 32'd7168; bus.req_divisor[3] = 32'd1024; bus.req_tag[3] = 4'd9;
    bus.req_valid = 4'b1000;
    @(negedge clock);
    checks++; if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL bp_grant: got %b expected 1000", bus.req_ready); end
    @(posedge clock); #1;
    bus.req_dividend[0] = 32'd2048; bus.req_divisor[0] = 32'd1024; bus.req_tag[0] = 4'd3;
    bus.req_valid = 4'b0001;
    rv = '0;
    for (int c = 0; c < 100 && rv == '0; c++) begin @(negedge clock); rv = bus.rsp_valid; end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid !== 4'b1000 || bus.rsp_quotient !== 32'd7168 || bus.rsp_tag !== 4'd9 || bus.rsp_dbz !== 1'b0 || bus.req_ready !== 4'b0) bad++;
      @(negedge clock);
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_stall_stable: got %0d bad cycles expected 0", bad); end
    bus.rsp_ready = 4'b1000;
    @(posedge clock); #1;
    bus.rsp_ready = '0;
    checks++; if (bus.req_ready !== 4'b0001 || bus.rsp_valid !== 4'b0) begin failures++; $display("FAIL bp_next_grant: got ready=%b valid=%b expected 0001/0000", bus.req_ready, bus.rsp_valid); end
    @(posedge clock); #1;
    bus.req_valid = '0;
    rv = '0;
    for (int c = 0; c < 100 && rv == '0; c++) begin @(negedge clock); rv = bus.rsp_valid; end
    checks++; if (rv !== 4'b0001 || bus.rsp_quotient !== 32'd2048 || bus.rsp_tag !== 4'd3) begin failures++; $display("FAIL bp_second_resp: got valid=%b q=%0d tag=%0d expected 0001/2048/3", rv, bus.rsp_quotient, bus.rsp_tag); end
    bus.rsp_ready = rv;
    @(posedge clock); #1;
    bus.rsp_ready = '0;
  endtask

  task automatic test_reset_mid_busy;
    int bad;
    bus.req_dividend[0] = 32'd3072; bus.req_divisor[0] = 32'd2048; bus.req_tag[0] = 4'd2;
    bus.req_valid = 4'b0001;
    @(negedge clock);
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL rst_mid_grant: got %b expected 0001", bus.req_ready); end
    @(posedge clock); #1;
    bus.req_dividend[3] = 32'd1024; bus.req_divisor[3] = 32'd1024; bus.req_tag[3] = 4'd6;
    bus.req_valid = 4'b1001;
    repeat (29) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (bus.rsp_valid !== 4'b0 || bus.req_ready !== 4'b0) begin failures++; $display("FAIL rst_mid_outputs: got valid=%b ready=%b expected 0000/0000", bus.rsp_valid, bus.req_ready); end
    checks++; if (bus.rsp_quotient !== 32'd0 || bus.rsp_tag !== 4'd0) begin failures++; $display("FAIL rst_mid_result: got q=%h tag=%0d expected 0/0", bus.rsp_quotient, bus.rsp_tag); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL rst_mid_first_grant: got %b expected 0001", bus.req_ready); end
    bus.req_valid = '0;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (bus.rsp_valid !== 4'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rst_mid_no_response: got %0d cycles with rsp_valid expected 0", bad); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_signs;
    test_dbz;
    test_round_robin;
    test_back_pressure;
    test_reset_mid_busy;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
